// File: rtl/argmax_top2.sv
// Top-2 argmax over a captured vector of signed scores, P elements per scan cycle.
// Define ARGMAX_MARGIN_EN to add the margin / low_conf outputs.

module argmax_top2_lane #(
  parameter int WIDTH = 16,
  parameter int IW    = 4
) (
  input  logic                    en,
  input  logic [IW-1:0]           idx,
  input  logic signed [WIDTH-1:0] val,
  input  logic signed [WIDTH-1:0] in_t1_val,
  input  logic [IW-1:0]           in_t1_idx,
  input  logic signed [WIDTH-1:0] in_t2_val,
  input  logic [IW-1:0]           in_t2_idx,
  output logic signed [WIDTH-1:0] out_t1_val,
  output logic [IW-1:0]           out_t1_idx,
  output logic signed [WIDTH-1:0] out_t2_val,
  output logic [IW-1:0]           out_t2_idx
);
  always_comb begin
    out_t1_val = in_t1_val;
    out_t1_idx = in_t1_idx;
    out_t2_val = in_t2_val;
    out_t2_idx = in_t2_idx;
    if (en) begin
      if (val > in_t1_val) begin
        out_t1_val = val;
        out_t1_idx = idx;
        // element 0 overtaking the initial index-0 entry must not evict the initial index-1 entry
        if (in_t1_idx != idx) begin
          out_t2_val = in_t1_val;
          out_t2_idx = in_t1_idx;
        end
      end else if (val > in_t2_val && idx != in_t1_idx) begin
        out_t2_val = val;
        out_t2_idx = idx;
      end
    end
  end
endmodule

module argmax_top2 #(
  parameter int WIDTH  = 16,
  parameter int SIZE   = 10,
  parameter int P      = 4,
  parameter int THRESH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SIZE*WIDTH-1:0]     data_flat,
  output logic                      ack,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(SIZE)-1:0]   max_index,
  output logic [$clog2(SIZE)-1:0]   second_index,
  output logic signed [WIDTH-1:0]   max_value
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [WIDTH-1:0]          margin,
  output logic                      low_conf
`endif
);
  localparam int N  = (SIZE + P - 1) / P;
  localparam int NP = N * P;
  localparam int SW = NP * WIDTH;
  localparam int IW = $clog2(NP + 1);
  localparam int XW = $clog2(SIZE);
  localparam logic signed [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nxt;

  // snapshot shifts down by P elements per cycle so lane l always reads snap[l]
  logic [NP-1:0][WIDTH-1:0] snap;
  logic [IW-1:0]            base;
  logic signed [WIDTH-1:0]  t1_val, t2_val;
  logic [IW-1:0]            t1_idx, t2_idx;
  logic                     capture, last;

  logic [P:0][WIDTH-1:0] c1v, c2v;
  logic [P:0][IW-1:0]    c1i, c2i;

  assign capture = (state == IDLE) && start;
  assign last    = (state == SCAN) && (base == IW'((N - 1) * P));

  assign c1v[0] = t1_val;
  assign c1i[0] = t1_idx;
  assign c2v[0] = t2_val;
  assign c2i[0] = t2_idx;

  for (genvar l = 0; l < P; l++) begin : g_lane
    logic [IW-1:0] lane_idx;
    assign lane_idx = base + IW'(l);
    argmax_top2_lane #(.WIDTH(WIDTH), .IW(IW)) u_lane (
      .en        (lane_idx < IW'(SIZE)),
      .idx       (lane_idx),
      .val       (snap[l]),
      .in_t1_val (c1v[l]),
      .in_t1_idx (c1i[l]),
      .in_t2_val (c2v[l]),
      .in_t2_idx (c2i[l]),
      .out_t1_val(c1v[l+1]),
      .out_t1_idx(c1i[l+1]),
      .out_t2_val(c2v[l+1]),
      .out_t2_idx(c2i[l+1])
    );
  end

`ifdef ARGMAX_MARGIN_EN
  logic signed [WIDTH:0] diff;
  assign diff = {c1v[P][WIDTH-1], c1v[P]} - {c2v[P][WIDTH-1], c2v[P]};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ack          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      snap         <= '0;
      base         <= '0;
      t1_val       <= '0;
      t1_idx       <= '0;
      t2_val       <= '0;
      t2_idx       <= '0;
      max_index    <= '0;
      second_index <= '0;
      max_value    <= '0;
`ifdef ARGMAX_MARGIN_EN
      margin       <= '0;
      low_conf     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      ack   <= capture;
      done  <= last;
      busy  <= (state_nxt == SCAN);
      if (capture) begin
        snap   <= SW'(data_flat);
        base   <= '0;
        t1_val <= MIN;
        t1_idx <= IW'(0);
        t2_val <= MIN;
        t2_idx <= IW'(1);
      end else if (state == SCAN) begin
        snap   <= snap >> (P * WIDTH);
        base   <= base + IW'(P);
        t1_val <= c1v[P];
        t1_idx <= c1i[P];
        t2_val <= c2v[P];
        t2_idx <= c2i[P];
        if (last) begin
          max_index    <= c1i[P][XW-1:0];
          second_index <= c2i[P][XW-1:0];
          max_value    <= c1v[P];
`ifdef ARGMAX_MARGIN_EN
          margin       <= diff[WIDTH-1:0];
          low_conf     <= $unsigned(diff) < {1'b0, WIDTH'(THRESH)};
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_argmax_top2.sv
// Directed bench for argmax_top2 at default parameters (margin checks when ARGMAX_MARGIN_EN is set).
module tb_argmax_top2;
  logic         clk, rst, start;
  logic [159:0] data_flat;
  logic         ack, busy, done;
  logic [3:0]   max_index, second_index;
  logic [15:0]  max_value;
`ifdef ARGMAX_MARGIN_EN
  logic [15:0]  margin;
  logic         low_conf;
`endif
  int passed = 0;
  int total  = 0;
  int vec[10];

  argmax_top2 dut (
    .clk(clk), .rst(rst), .start(start), .data_flat(data_flat),
    .ack(ack), .busy(busy), .done(done),
    .max_index(max_index), .second_index(second_index), .max_value(max_value)
`ifdef ARGMAX_MARGIN_EN
    , .margin(margin), .low_conf(low_conf)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic load_vec;
    for (int k = 0; k < 10; k++) data_flat[k*16 +: 16] = 16'(vec[k]);
  endtask

  // drive a one-cycle start; returns at the negedge where ack should be visible
  task automatic launch;
    @(negedge clk);
    load_vec();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
  endtask

  task automatic test_reset;
    rst = 1; start = 0; data_flat = '0;
    #3 rst = 0;
    #1;
    total++; if (ack !== 1'b0) $display("FAIL reset ack got %b want 0", ack); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset done got %b want 0", done); else passed++;
    total++; if (max_index !== 4'd0) $display("FAIL reset max_index got %0d want 0", max_index); else passed++;
    total++; if (second_index !== 4'd0) $display("FAIL reset second_index got %0d want 0", second_index); else passed++;
    total++; if (max_value !== 16'h0000) $display("FAIL reset max_value got %h want 0000", max_value); else passed++;
`ifdef ARGMAX_MARGIN_EN
    total++; if (margin !== 16'h0000) $display("FAIL reset margin got %h want 0000", margin); else passed++;
    total++; if (low_conf !== 1'b0) $display("FAIL reset low_conf got %b want 0", low_conf); else passed++;
`endif
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_basic;
    int lat;
    vec = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
    launch();
    total++; if (ack !== 1'b1) $display("FAIL basic ack got %b want 1", ack); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL basic busy got %b want 1", busy); else passed++;
    wait_done(lat);
    total++; if (lat !== 3) $display("FAIL basic latency got %0d want 3", lat); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic busy_at_done got %b want 0", busy); else passed++;
    total++; if (max_index !== 4'd2) $display("FAIL basic max_index got %0d want 2", max_index); else passed++;
    total++; if (second_index !== 4'd4) $display("FAIL basic second_index got %0d want 4", second_index); else passed++;
    total++; if (max_value !== 16'd7) $display("FAIL basic max_value got %h want 0007", max_value); else passed++;
`ifdef ARGMAX_MARGIN_EN
    total++; if (margin !== 16'd0) $display("FAIL basic margin got %0d want 0", margin); else passed++;
    total++; if (low_conf !== 1'b1) $display("FAIL basic low_conf got %b want 1", low_conf); else passed++;
`endif
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL basic done_pulse got %b want 0", done); else passed++;
    total++; if (max_index !== 4'd2) $display("FAIL basic hold max_index got %0d want 2", max_index); else passed++;
  endtask

  task automatic test_all_min;
    int lat;
    vec = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    launch();
    wait_done(lat);
    total++; if (lat !== 3) $display("FAIL all_min latency got %0d want 3", lat); else passed++;
    total++; if (max_index !== 4'd0) $display("FAIL all_min max_index got %0d want 0", max_index); else passed++;
    total++; if (second_index !== 4'd1) $display("FAIL all_min second_index got %0d want 1", second_index); else passed++;
    total++; if (max_value !== 16'h8000) $display("FAIL all_min max_value got %h want 8000", max_value); else passed++;
`ifdef ARGMAX_MARGIN_EN
    total++; if (margin !== 16'd0) $display("FAIL all_min margin got %0d want 0", margin); else passed++;
`endif
  endtask

  task automatic test_top_lanes;
    int lat;
    vec = '{0, 0, 0, 0, 0, 0, 0, 0, 99, 100};
    launch();
    wait_done(lat);
    total++; if (lat !== 3) $display("FAIL top_lanes latency got %0d want 3", lat); else passed++;
    total++; if (max_index !== 4'd9) $display("FAIL top_lanes max_index got %0d want 9", max_index); else passed++;
    total++; if (second_index !== 4'd8) $display("FAIL top_lanes second_index got %0d want 8", second_index); else passed++;
    total++; if (max_value !== 16'd100) $display("FAIL top_lanes max_value got %0d want 100", max_value); else passed++;
`ifdef ARGMAX_MARGIN_EN
    total++; if (margin !== 16'd1) $display("FAIL top_lanes margin got %0d want 1", margin); else passed++;
    total++; if (low_conf !== 1'b0) $display("FAIL top_lanes low_conf got %b want 0", low_conf); else passed++;
`endif
  endtask

  task automatic test_extremes;
    int lat;
    vec = '{32767, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    launch();
    wait_done(lat);
    total++; if (max_index !== 4'd0) $display("FAIL extremes max_index got %0d want 0", max_index); else passed++;
    total++; if (second_index !== 4'd1) $display("FAIL extremes second_index got %0d want 1", second_index); else passed++;
    total++; if (max_value !== 16'h7fff) $display("FAIL extremes max_value got %h want 7fff", max_value); else passed++;
`ifdef ARGMAX_MARGIN_EN
    total++; if (margin !== 16'hffff) $display("FAIL extremes margin got %0d want 65535", margin); else passed++;
    total++; if (low_conf !== 1'b0) $display("FAIL extremes low_conf got %b want 0", low_conf); else passed++;
`endif
  endtask

  task automatic test_snapshot;
    int acks, dones;
    logic [3:0] mi, si;
    vec = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
    launch();
    acks = int'(ack); dones = 0; mi = 4'hf; si = 4'hf;
    vec = '{0, 0, 0, 0, 0, 1000, 0, 0, 0, 500};
    load_vec();
    start = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) start = 0;
      acks += int'(ack);
      dones += int'(done);
      if (done) begin mi = max_index; si = second_index; end
    end
    total++; if (acks !== 1) $display("FAIL snapshot ack_count got %0d want 1", acks); else passed++;
    total++; if (dones !== 1) $display("FAIL snapshot done_count got %0d want 1", dones); else passed++;
    total++; if (mi !== 4'd2) $display("FAIL snapshot max_index got %0d want 2", mi); else passed++;
    total++; if (si !== 4'd4) $display("FAIL snapshot second_index got %0d want 4", si); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat;
    vec = '{0, 0, 0, 0, 0, 0, 0, 0, 99, 100};
    @(negedge clk);
    load_vec();
    start = 1;
    @(negedge clk);
    total++; if (ack !== 1'b1) $display("FAIL b2b first ack got %b want 1", ack); else passed++;
    wait_done(lat);
    total++; if (lat !== 3) $display("FAIL b2b first latency got %0d want 3", lat); else passed++;
    total++; if (max_index !== 4'd9) $display("FAIL b2b first max_index got %0d want 9", max_index); else passed++;
    vec = '{32767, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    load_vec();
    @(negedge clk);
    start = 0;
    total++; if (ack !== 1'b1) $display("FAIL b2b second ack got %b want 1", ack); else passed++;
    wait_done(lat);
    total++; if (lat !== 3) $display("FAIL b2b second latency got %0d want 3", lat); else passed++;
    total++; if (max_value !== 16'h7fff) $display("FAIL b2b second max_value got %h want 7fff", max_value); else passed++;
  endtask

  task automatic test_reset_abort;
    int lat, dones;
    vec = '{3, -1, 7, 2, 7, 0, -5, 1, 6, 4};
    launch();
    @(negedge clk);
    rst = 0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort busy got %b want 0", busy); else passed++;
    total++; if (max_value !== 16'h0000) $display("FAIL abort max_value got %h want 0000", max_value); else passed++;
    total++; if (second_index !== 4'd0) $display("FAIL abort second_index got %0d want 0", second_index); else passed++;
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dones += int'(done);
    end
    total++; if (dones !== 0) $display("FAIL abort done_count got %0d want 0", dones); else passed++;
    rst = 1;
    vec = '{0, 0, 0, 0, 0, 0, 0, 0, 99, 100};
    launch();
    total++; if (ack !== 1'b1) $display("FAIL abort restart ack got %b want 1", ack); else passed++;
    wait_done(lat);
    total++; if (lat !== 3) $display("FAIL abort restart latency got %0d want 3", lat); else passed++;
    total++; if (max_index !== 4'd9) $display("FAIL abort restart max_index got %0d want 9", max_index); else passed++;
    total++; if (second_index !== 4'd8) $display("FAIL abort restart second_index got %0d want 8", second_index); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_min();
    test_top_lanes();
    test_extremes();
    test_snapshot();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/argmax_top2.md
ARGMAX_TOP2 -- requirements
Module: argmax_top2

Interface
REQ-001 Parameter WIDTH, default 16: bit width of each signed two's-complement score.
REQ-002 Parameter SIZE, default 10: number of scores per vector; legal range SIZE >= 2.
REQ-003 Parameter P, default 4: scores compared per scan cycle; legal range 1 <= P <= SIZE.
REQ-004 Parameter THRESH, default 1: unsigned WIDTH-bit low-confidence margin threshold; used only under ARGMAX_MARGIN_EN.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  request; level-sampled only in IDLE.
REQ-008 data_flat  input  SIZE*WIDTH  signed scores; element k at bits [k*WIDTH +: WIDTH].
REQ-009 ack  output  1  one-cycle pulse confirming vector capture.
REQ-010 busy  output  1  high from capture through the final scan cycle.
REQ-011 done  output  1  one-cycle pulse; result outputs valid from this cycle.
REQ-012 max_index  output  clog2(SIZE)  index of the largest score.
REQ-013 second_index  output  clog2(SIZE)  index of the second-largest score.
REQ-014 max_value  output  WIDTH  signed largest score.
REQ-015 margin  output  WIDTH  unsigned max_value minus second score; present only under ARGMAX_MARGIN_EN.
REQ-016 low_conf  output  1  margin < THRESH; present only under ARGMAX_MARGIN_EN.

Function
REQ-017 States SHALL be IDLE and SCAN.
REQ-018 In IDLE with start=1 at edge E0: all of data_flat SHALL be captured into an internal snapshot; ack=1 and busy=1 after E0; state SHALL go to SCAN.
REQ-019 ack SHALL be high for exactly one cycle per capture.
REQ-020 Scan SHALL use only the snapshot; data_flat changes after E0 SHALL NOT affect the result.
REQ-021 With N = ceil(SIZE/P), edge E(j+1), j=0..N-1, SHALL process elements j*P .. j*P+P-1; lanes >= SIZE SHALL be masked and never selected.
REQ-022 Running top-1/top-2 SHALL initialise at E0 to (MIN, index 0)/(MIN, index 1), MIN = -2^(WIDTH-1).
REQ-023 An element SHALL replace top-1 (demoting old top-1 to top-2) only if strictly greater than top-1; otherwise replace top-2 only if strictly greater than top-2 and not the current top-1 index; ties resolve to the lowest index.
REQ-024 At edge EN: max_index, second_index, max_value (and margin, low_conf) SHALL update; done=1 for one cycle; busy=0; state returns to IDLE.
REQ-025 Result outputs SHALL hold until the next done or reset.
REQ-026 start during SCAN SHALL be ignored; start held high through EN SHALL launch a new capture at E(N+1).
REQ-027 Latency: done SHALL assert N cycles after the capture edge (3 for defaults).
REQ-028 Margin arithmetic SHALL use WIDTH+1-bit signed subtraction; the non-negative result SHALL fit WIDTH unsigned bits without saturation.

Reset
REQ-029 rst=0 SHALL immediately force IDLE and all outputs, snapshot and running registers to 0, aborting any scan without a done pulse.
REQ-030 The first start after rst deasserts SHALL behave as from power-up.

Configuration
REQ-031 Macro ARGMAX_MARGIN_EN defined: margin and low_conf ports and logic SHALL exist per REQ-015/016/024/028.
REQ-032 ARGMAX_MARGIN_EN undefined: margin and low_conf ports and logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=16, SIZE=10, P=4, THRESH=1, ARGMAX_MARGIN_EN defined)
REQ-033 data=[3,-1,7,2,7,0,-5,1,6,4], start pulse -> ack next cycle, done 3 cycles after capture; max_index=2, second_index=4, max_value=7, margin=0, low_conf=1.
REQ-034 All elements -32768 -> max_index=0, second_index=1, max_value=-32768, margin=0.
REQ-035 Element 9=100, element 8=99, rest 0 -> max_index=9, second_index=8, margin=1, low_conf=0; masked lanes 10,11 never selected.
REQ-036 Element 0=32767, rest -32768 -> max_index=0, second_index=1, margin=65535.
REQ-037 data_flat changed and start re-pulsed one cycle after capture -> result reflects captured vector only; exactly one ack and one done.
REQ-038 rst driven low at second scan cycle -> all outputs 0 immediately, no done; next start yields the correct result in 3 cycles.
